// File: rtl/mips_multicycle_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_multicycle_ctrl_pkg                                          |
// | Brief  : Shared MIPS control types: ALU operation class, opcodes, control  |
// |          FSM states and the datapath control word.                         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mips_multicycle_ctrl_pkg;

  // Operation class handed to the ALU decoder.
  typedef enum logic [1:0] {
    ADD_Op    = 2'b00,
    SUB_Op    = 2'b01,
    R_Type_Op = 2'b10
  } alu_op_t;

  // Opcodes (instr[31:26]) that the control FSM implements.
  typedef enum logic [5:0] {
    RTYPE_Op = 6'b000000,
    J_Op     = 6'b000010,
    BEQ_Op   = 6'b000100,
    ADDI_Op  = 6'b001000,
    LW_Op    = 6'b100011,
    SW_Op    = 6'b101011
  } opcode_t;

  typedef enum logic [3:0] {
    RESET_S  = 4'd0,
    FETCH_S  = 4'd1,
    DECODE_S = 4'd2,
    MEMADR_S = 4'd3,
    MEMRD_S  = 4'd4,
    MEMWB_S  = 4'd5,
    MEMWR_S  = 4'd6,
    EXEC_S   = 4'd7,
    ALUWB_S  = 4'd8,
    BRANCH_S = 4'd9,
    ADDIEX_S = 4'd10,
    ADDIWB_S = 4'd11,
    JUMP_S   = 4'd12,
    ERR_S    = 4'd13
  } ctrl_state_t;

  // Raw per-state control word; pc_en is formed later from pc_write/branch.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_t    alu_op;
  } ctrl_word_t;

  // States that touch memory and may have to wait for it.
  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == FETCH_S) || (s == MEMRD_S) || (s == MEMWR_S);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_out_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_ctrl_out_decode                                              |
// | Brief  : Combinational state -> control word table of the multicycle MIPS  |
// |          control FSM. Any field not set for a state is 0.                  |
// | Ports  : i_state  current FSM state                                        |
// |          o_ctrl   decoded control word                                     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mips_ctrl_out_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  ctrl_state_t i_state,
  output ctrl_word_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH_S: begin
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.pc_write  = 1'b1;
      end
      DECODE_S: begin
        // Branch target PC+4 + (imm << 2) is precomputed here.
        o_ctrl.alu_src_b = 2'b11;
      end
      MEMADR_S, ADDIEX_S: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
      end
      MEMRD_S: begin
        o_ctrl.i_or_d = 1'b1;
      end
      MEMWB_S: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      MEMWR_S: begin
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      EXEC_S: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = R_Type_Op;
      end
      ALUWB_S: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      BRANCH_S: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = SUB_Op;
        o_ctrl.pc_src    = 2'b01;
        o_ctrl.branch    = 1'b1;
      end
      ADDIWB_S: begin
        o_ctrl.reg_write = 1'b1;
      end
      JUMP_S: begin
        o_ctrl.pc_src   = 2'b10;
        o_ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mips_multicycle_ctrl                                              |
// | Brief  : Main Moore control FSM of the multicycle MIPS core. Sequences     |
// |          FETCH/DECODE/EXECUTE/MEM/WB steps, drives datapath controls and   |
// |          alu_op, flags illegal opcodes and counts retired instructions.    |
// | Params : ERR_HALT  1: illegal opcode parks the FSM in ERR_S until reset    |
// |                    0: flag it and resume at FETCH_S                        |
// |          CNT_W     width of the retired-instruction counter                |
// | Macro  : MIPS_CTRL_MEM_WAIT_EN  FETCH/MEMRD/MEMWR wait for i_mem_ready     |
// | Ports  : clk, rst_n (async, active low); i_opcode, i_zero, i_mem_ready;    |
// |          o_pc_en .. o_alu_op datapath controls; o_illegal_op sticky flag;  |
// |          o_instr_cnt retired instruction count                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int ERR_HALT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_i_or_d,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_pc_src,
  output alu_op_t          o_alu_op,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t      r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  ctrl_word_t       w_ctrl;
  logic             w_mem_ok;
  logic             w_hold;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign w_mem_ok = i_mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = i_mem_ready;
  assign w_mem_ok = 1'b1;
`endif

  // A memory state that has not seen mem_ready is stalled this cycle.
  assign w_hold = is_wait_state(r_state) && !w_mem_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET_S;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        RESET_S:  r_state <= FETCH_S;
        FETCH_S:  if (w_mem_ok) r_state <= DECODE_S;
        DECODE_S: begin
          case (i_opcode)
            LW_Op, SW_Op: r_state <= MEMADR_S;
            RTYPE_Op:     r_state <= EXEC_S;
            BEQ_Op:       r_state <= BRANCH_S;
            ADDI_Op:      r_state <= ADDIEX_S;
            J_Op:         r_state <= JUMP_S;
            default: begin
              r_state   <= ERR_S;
              r_illegal <= 1'b1;
            end
          endcase
        end
        MEMADR_S: r_state <= (i_opcode == LW_Op) ? MEMRD_S : MEMWR_S;
        MEMRD_S:  if (w_mem_ok) r_state <= MEMWB_S;
        MEMWR_S: begin
          if (w_mem_ok) begin
            r_state <= FETCH_S;
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        // Final steps of an instruction: retire it on the way back to FETCH.
        MEMWB_S, ALUWB_S, ADDIWB_S, BRANCH_S, JUMP_S: begin
          r_state <= FETCH_S;
          r_cnt   <= r_cnt + c_cnt_one;
        end
        EXEC_S:   r_state <= ALUWB_S;
        ADDIEX_S: r_state <= ADDIWB_S;
        // PC was already bumped in FETCH, so resuming skips the bad word.
        ERR_S:    if (ERR_HALT == 0) r_state <= FETCH_S;
        default:  r_state <= RESET_S;
      endcase
    end
  end

  mips_ctrl_out_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Write strobes fire only in the cycle the memory step completes.
  assign o_pc_en      = (w_ctrl.pc_write & ~w_hold) | (w_ctrl.branch & i_zero);
  assign o_ir_write   = w_ctrl.ir_write  & ~w_hold;
  assign o_mem_write  = w_ctrl.mem_write & ~w_hold;
  assign o_i_or_d     = w_ctrl.i_or_d;
  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_reg_write  = w_ctrl.reg_write;
  assign o_alu_src_a  = w_ctrl.alu_src_a;
  assign o_alu_src_b  = w_ctrl.alu_src_b;
  assign o_pc_src     = w_ctrl.pc_src;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_illegal_op = r_illegal;
  assign o_instr_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mips_multicycle_ctrl                                           |
// | Brief  : Self-checking bench for mips_multicycle_ctrl. Two instances:      |
// |          A (ERR_HALT=1, CNT_W=32) and B (ERR_HALT=0, CNT_W=3, so the       |
// |          counter wraps). Expected controls come from a per-instruction    |
// |          step model built from the instruction timing rules.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic [5:0] opcode    = 6'd0;
  logic       zero      = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_pc_en, a_i_or_d, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a;
  logic b_pc_en, b_i_or_d, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a;
  logic [1:0] a_alu_src_b, a_pc_src, b_alu_src_b, b_pc_src;
  alu_op_t a_alu_op, b_alu_op;
  logic a_ill, b_ill;
  logic [31:0] a_cnt;
  logic [2:0]  b_cnt;

  mips_multicycle_ctrl #(.ERR_HALT(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_en(a_pc_en), .o_i_or_d(a_i_or_d), .o_mem_write(a_mem_write), .o_ir_write(a_ir_write),
    .o_reg_dst(a_reg_dst), .o_mem_to_reg(a_mem_to_reg), .o_reg_write(a_reg_write),
    .o_alu_src_a(a_alu_src_a), .o_alu_src_b(a_alu_src_b), .o_pc_src(a_pc_src),
    .o_alu_op(a_alu_op), .o_illegal_op(a_ill), .o_instr_cnt(a_cnt));

  mips_multicycle_ctrl #(.ERR_HALT(0), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_en(b_pc_en), .o_i_or_d(b_i_or_d), .o_mem_write(b_mem_write), .o_ir_write(b_ir_write),
    .o_reg_dst(b_reg_dst), .o_mem_to_reg(b_mem_to_reg), .o_reg_write(b_reg_write),
    .o_alu_src_a(b_alu_src_a), .o_alu_src_b(b_alu_src_b), .o_pc_src(b_pc_src),
    .o_alu_op(b_alu_op), .o_illegal_op(b_ill), .o_instr_cnt(b_cnt));

  // {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op}
  logic [13:0] a_word, b_word;
  assign a_word = {a_pc_en, a_i_or_d, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                   a_reg_write, a_alu_src_a, a_alu_src_b, a_pc_src, a_alu_op};
  assign b_word = {b_pc_en, b_i_or_d, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                   b_reg_write, b_alu_src_a, b_alu_src_b, b_pc_src, b_alu_op};

  int vectors     = 0;
  int miscompares = 0;
  int model_a     = 0;   // retired count expected from A
  int model_b     = 0;   // retired count expected from B (mod 8)
  bit ill_a       = 1'b0;
  bit ill_b       = 1'b0;
  bit halted_a    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  function automatic int n_steps(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      default: return 3;   // BEQ, J, and an illegal word (FETCH, DECODE, ERR)
    endcase
  endfunction

  // Expected control word for step s (0 = fetch) of an instruction.
  function automatic logic [13:0] exp_word(input logic [5:0] op, input int s, input logic z);
    logic pe, iod, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, ps, ao;
    pe = 0; iod = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    if (s == 0) begin
      pe = 1; irw = 1; sb = 2'b01;
    end else if (s == 1) begin
      sb = 2'b11;
    end else begin
      case (op)
        6'b100011, 6'b101011: begin
          if (s == 2) begin sa = 1; sb = 2'b10; end
          if (s == 3) begin iod = 1; mw = (op == 6'b101011); end
          if (s == 4) begin m2r = 1; rw = 1; end
        end
        6'b000000: begin
          if (s == 2) begin sa = 1; ao = 2'b10; end
          if (s == 3) begin rd = 1; rw = 1; end
        end
        6'b000100: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
        6'b001000: begin
          if (s == 2) begin sa = 1; sb = 2'b10; end
          if (s == 3) rw = 1;
        end
        6'b000010: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
    end
    return {pe, iod, mw, irw, rd, m2r, rw, sa, sb, ps, ao};
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic z);
    int n;
    n = n_steps(op);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (s == 0) opcode = op;
      zero = z;
`ifdef MIPS_CTRL_MEM_WAIT_EN
      mem_ready = 1'b1;
`else
      mem_ready = ($urandom_range(0, 1) != 0);
`endif
      #1;
      if (s == 0) begin
        check("cnt_a", a_cnt, 32'(model_a));
        check("cnt_b", 32'(b_cnt), 32'(model_b));
      end
      check("ctrl_b", 32'(b_word), 32'(exp_word(op, s, z)));
      check("ill_b", 32'(b_ill), 32'(ill_b || (!legal(op) && s >= 2)));
      if (halted_a) begin
        check("halt_ctrl_a", 32'(a_word), 32'd0);
        check("halt_ill_a", 32'(a_ill), 32'd1);
      end else begin
        check("ctrl_a", 32'(a_word), 32'(exp_word(op, s, z)));
        check("ill_a", 32'(a_ill), 32'(ill_a || (!legal(op) && s >= 2)));
      end
    end
    if (legal(op)) begin
      if (!halted_a) model_a++;
      model_b = (model_b + 1) % 8;
    end else begin
      ill_b = 1'b1;
      if (!halted_a) begin
        ill_a    = 1'b1;
        halted_a = 1'b1;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl_a"}, 32'(a_word), 32'd0);
    check({tag, "_ctrl_b"}, 32'(b_word), 32'd0);
    check({tag, "_cnt_a"}, a_cnt, 32'd0);
    check({tag, "_cnt_b"}, 32'(b_cnt), 32'd0);
    check({tag, "_ill_a"}, 32'(a_ill), 32'd0);
    check({tag, "_ill_b"}, 32'(b_ill), 32'd0);
  endtask

  task automatic clear_models();
    model_a = 0; model_b = 0; ill_a = 0; ill_b = 0; halted_a = 0;
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         cnt_a;
    int         cnt_b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [5:0] op;
    tbl[0] = '{6'b100011, 1'b0, 1, 1};   // LW
    tbl[1] = '{6'b101011, 1'b1, 2, 2};   // SW
    tbl[2] = '{6'b000000, 1'b0, 3, 3};   // R-type
    tbl[3] = '{6'b000010, 1'b0, 4, 4};   // J
    tbl[4] = '{6'b000100, 1'b1, 5, 5};   // BEQ taken
    tbl[5] = '{6'b000100, 1'b0, 6, 6};   // BEQ not taken
    tbl[6] = '{6'b001000, 1'b1, 7, 7};   // ADDI
    tbl[7] = '{6'b100011, 1'b1, 8, 0};   // LW, B counter wraps
    tbl[8] = '{6'b000000, 1'b1, 9, 1};   // R-type
    tbl[9] = '{6'b000010, 1'b1, 10, 2};  // J

    // Reset held for three cycles.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_reset_state("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; counts checked just after each retiring edge.
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].z);
      @(posedge clk);
      #1;
      check("tbl_cnt_a", a_cnt, 32'(tbl[i].cnt_a));
      check("tbl_cnt_b", 32'(b_cnt), 32'(tbl[i].cnt_b));
    end

    // Asynchronous reset in the middle of an LW (MEMADR step).
    @(negedge clk); opcode = 6'b100011; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // SW with memory stalling three cycles in MEMWR: strobe only on the ready cycle.
    run_instr(6'b000000, 1'b0);
    @(negedge clk); opcode = 6'b101011; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      mem_ready = (h == 3);
      #1;
      check("memwr_hold_b", 32'(b_word),
            32'(exp_word(6'b101011, 3, 1'b0) & ((h == 3) ? 14'h3fff : 14'h37ff)));
    end
    model_a++; model_b++;
    @(posedge clk);
    #1;
    check("memwr_cnt_b", 32'(b_cnt), 32'(model_b));
    // Fetch stalled, then reset dropped mid-hold.
    @(negedge clk); mem_ready = 1'b0;
    #1;
    check("fetch_hold_a", 32'(a_word), 32'(exp_word(6'b000000, 0, 1'b0) & 14'h1bff));
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("hold_rst");
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Random legal program on both instances.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        default: op = 6'b000010;
      endcase
      run_instr(op, ($urandom_range(0, 1) != 0));
    end

    // Program with illegal words: A halts on the first, B keeps going.
    run_instr(6'b111111, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        case ($urandom_range(0, 5))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          default: op = 6'b000010;
        endcase
      end
      run_instr(op, ($urandom_range(0, 1) != 0));
    end

    // Reset clears the sticky flag and the halt.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("final_rst");
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'b000010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
